// File: rtl/prog_counter_pkg.sv
// Shared encodings for the programmable counter: mode/direction values and the
// per-edge event selector used by the next-state mux.
package prog_counter_pkg;

  localparam logic CNT_MODE_WRAP = 1'b0;
  localparam logic CNT_MODE_SAT  = 1'b1;
  localparam logic CNT_DIR_UP    = 1'b1;
  localparam logic CNT_DIR_DOWN  = 1'b0;

  typedef enum logic [1:0] {
    EV_HOLD = 2'd0,
    EV_LOAD = 2'd1,
    EV_STEP = 2'd2
  } cnt_event_e;

endpackage

// File: rtl/cnt_prescaler.sv
// Enable-gated prescaler: asserts step on every (prescale+1)-th enabled clock.
// A prescale lowered below the running phase fires a step immediately.
module cnt_prescaler #(
  parameter int PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  clr,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  step
);

  logic [PRESCALE_W-1:0] r_pre_cnt;
  logic                  w_hit;

  assign w_hit = (r_pre_cnt >= prescale);
  assign step  = en & w_hit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pre_cnt <= '0;
    end else if (clr) begin
      r_pre_cnt <= '0;
    end else if (en) begin
      r_pre_cnt <= w_hit ? '0 : r_pre_cnt + PRESCALE_W'(1);
    end
  end

endmodule

// File: rtl/prog_counter.sv
// Programmable up/down counter with prescaler, parallel load, runtime limit,
// wrap/saturate modes, a one-cycle terminal-count pulse and a saturation flag.
module prog_counter
  import prog_counter_pkg::*;
#(
  parameter int WIDTH      = 33,
  parameter int PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  up,
  input  logic                  mode,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_val,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic [WIDTH-1:0]      limit,
  output logic [WIDTH-1:0]      count,
  output logic                  tc,
  output logic                  sat
);

  logic [WIDTH-1:0] r_count;
  logic             r_tc;
  logic [WIDTH-1:0] w_count_next;
  logic             w_tc_next;
  logic             w_step;
  logic             w_at_top;
  logic             w_at_zero;
  logic             w_is_sat;
  logic [WIDTH-1:0] w_inc;
  logic [WIDTH-1:0] w_dec;
  logic [WIDTH-1:0] w_load_clamped;
  cnt_event_e       w_event;

  cnt_prescaler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_prescaler (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .clr      (load),
    .prescale (prescale),
    .step     (w_step)
  );

  assign w_at_top       = (r_count >= limit);
  assign w_at_zero      = (r_count == '0);
  assign w_is_sat       = (mode == CNT_MODE_SAT);
  assign w_inc          = r_count + WIDTH'(1);
  // A limit lowered below the count pulls a down-step straight back into range.
  assign w_dec          = (r_count > limit) ? limit : r_count - WIDTH'(1);
  assign w_load_clamped = (load_val > limit) ? limit : load_val;

  always_comb begin
    w_event = EV_HOLD;
    if (load) begin
      w_event = EV_LOAD;
    end else if (w_step) begin
      w_event = EV_STEP;
    end
  end

  always_comb begin
    w_count_next = r_count;
    w_tc_next    = 1'b0;
    case (w_event)
      EV_LOAD: begin
        w_count_next = w_load_clamped;
      end
      EV_STEP: begin
        if (up == CNT_DIR_UP) begin
          if (w_at_top) begin
            w_count_next = (mode == CNT_MODE_WRAP) ? '0 : limit;
            w_tc_next    = (mode == CNT_MODE_WRAP);
          end else begin
            w_count_next = w_inc;
            w_tc_next    = w_is_sat & (w_inc == limit);
          end
        end else begin
          if (w_at_zero) begin
            w_count_next = (mode == CNT_MODE_WRAP) ? limit : '0;
            w_tc_next    = (mode == CNT_MODE_WRAP);
          end else begin
            w_count_next = w_dec;
            w_tc_next    = w_is_sat & (w_dec == '0);
          end
        end
      end
      default: begin
        w_count_next = r_count;
        w_tc_next    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
      r_tc    <= 1'b0;
    end else begin
      r_count <= w_count_next;
      r_tc    <= w_tc_next;
    end
  end

  assign count = r_count;
  assign tc    = r_tc;
  assign sat   = w_is_sat & (((up == CNT_DIR_UP) & w_at_top) |
                             ((up == CNT_DIR_DOWN) & w_at_zero));

endmodule

// File: tb/tb_prog_counter.sv
// Scoreboard bench for prog_counter: the driver predicts each edge's outcome from
// a behavioural model and queues it; a monitor compares after every clock edge.
module tb_prog_counter;
  import prog_counter_pkg::*;

  localparam int W  = 33;
  localparam int PW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en = 1'b0, up = 1'b1, mode = 1'b0, load = 1'b0;
  logic [W-1:0]  load_val = '0;
  logic [W-1:0]  limit = '0;
  logic [PW-1:0] prescale = '0;
  logic [W-1:0]  count;
  logic          tc, sat;

  prog_counter #(.WIDTH(W), .PRESCALE_W(PW)) dut (
    .clk(clk), .rst(rst), .en(en), .up(up), .mode(mode), .load(load),
    .load_val(load_val), .prescale(prescale), .limit(limit),
    .count(count), .tc(tc), .sat(sat)
  );

  always #20 clk = ~clk;

  typedef struct {
    logic [W-1:0] count;
    logic         tc;
    logic         sat;
  } exp_t;

  exp_t         sb[$];
  int           errors = 0;
  int           checks = 0;
  int           txn = 0;
  logic [W-1:0] m_count = '0;
  int           m_elapsed = 0;   // enabled clocks since last step, load or reset
  logic [W-1:0] all_ones;

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s txn=%0d got=%0h expected=%0h", name, txn, got, exp);
    end
  endtask

  // Behavioural reference: counting range is 0..limit, a step occurs once
  // prescale+1 enabled clocks have elapsed, load wins over everything.
  task automatic drive(input logic i_en, input logic i_up, input logic i_mode,
                       input logic i_load, input logic [W-1:0] i_lv,
                       input logic [PW-1:0] i_ps, input logic [W-1:0] i_lim);
    exp_t e;
    bit   stepping;
    @(negedge clk);
    en = i_en; up = i_up; mode = i_mode; load = i_load;
    load_val = i_lv; prescale = i_ps; limit = i_lim;
    stepping = i_en && (m_elapsed >= int'(i_ps));
    e.tc = 1'b0;
    if (i_load) begin
      m_count   = (i_lv > i_lim) ? i_lim : i_lv;
      m_elapsed = 0;
    end else begin
      if (i_en) m_elapsed = stepping ? 0 : m_elapsed + 1;
      if (stepping && i_up) begin
        if (m_count >= i_lim) begin
          m_count = i_mode ? i_lim : '0;
          e.tc    = !i_mode;
        end else begin
          m_count = m_count + 1;
          e.tc    = i_mode && (m_count == i_lim);
        end
      end else if (stepping) begin
        if (m_count == 0) begin
          m_count = i_mode ? '0 : i_lim;
          e.tc    = !i_mode;
        end else begin
          m_count = (m_count > i_lim) ? i_lim : m_count - 1;
          e.tc    = i_mode && (m_count == 0);
        end
      end
    end
    e.count = m_count;
    e.sat   = i_mode && ((i_up && m_count >= i_lim) || (!i_up && m_count == 0));
    sb.push_back(e);
  endtask

  always @(posedge clk) begin : monitor
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      txn++;
      check("count", count, e.count);
      check("tc", W'(tc), W'(e.tc));
      check("sat", W'(sat), W'(e.sat));
      $display("txn %0d: count=%0h tc=%0b sat=%0b", txn, count, tc, sat);
    end
  end

  initial begin
    logic [W-1:0] r_lim, r_lv;
    logic [PW-1:0] r_ps;
    all_ones = '1;

    // Reset state while held low
    limit = 9; up = CNT_DIR_UP; mode = CNT_MODE_SAT;
    repeat (3) @(negedge clk);
    check("reset_count", count, '0);
    check("reset_tc", W'(tc), '0);
    check("reset_sat", W'(sat), '0);
    mode = CNT_MODE_WRAP;
    @(negedge clk);
    rst = 1'b1;

    // Up/wrap at limit 9, every clock
    repeat (12) drive(1, CNT_DIR_UP, CNT_MODE_WRAP, 0, '0, 0, 9);

    // Prescale 3 with an enable gap
    drive(1, CNT_DIR_UP, CNT_MODE_WRAP, 1, '0, 3, 9);
    repeat (10) drive(1, CNT_DIR_UP, CNT_MODE_WRAP, 0, '0, 3, 9);
    repeat (5)  drive(0, CNT_DIR_UP, CNT_MODE_WRAP, 0, '0, 3, 9);
    repeat (10) drive(1, CNT_DIR_UP, CNT_MODE_WRAP, 0, '0, 3, 9);

    // Saturating down from 3, then reverse direction
    drive(1, CNT_DIR_DOWN, CNT_MODE_SAT, 1, 3, 0, 9);
    repeat (6) drive(1, CNT_DIR_DOWN, CNT_MODE_SAT, 0, '0, 0, 9);
    repeat (2) drive(1, CNT_DIR_UP, CNT_MODE_SAT, 0, '0, 0, 9);

    // Load clamped to limit while a step is due, then a fresh load
    drive(1, CNT_DIR_UP, CNT_MODE_WRAP, 1, 200, 0, 100);
    drive(1, CNT_DIR_UP, CNT_MODE_WRAP, 1, 50, 3, 100);
    repeat (6) drive(1, CNT_DIR_UP, CNT_MODE_WRAP, 0, '0, 3, 100);

    // Asynchronous reset between edges at count 37
    drive(1, CNT_DIR_UP, CNT_MODE_WRAP, 1, 37, 2, 100);
    drive(0, CNT_DIR_UP, CNT_MODE_WRAP, 0, '0, 2, 100);
    @(posedge clk);
    #5 rst = 1'b0;
    #1;
    check("async_rst_count", count, '0);
    check("async_rst_tc", W'(tc), '0);
    m_count = '0; m_elapsed = 0;
    @(negedge clk);
    rst = 1'b1;
    repeat (7) drive(1, CNT_DIR_UP, CNT_MODE_WRAP, 0, '0, 2, 100);

    // Full-width binary wrap
    drive(1, CNT_DIR_UP, CNT_MODE_WRAP, 1, all_ones - 1, 0, all_ones);
    repeat (3) drive(1, CNT_DIR_UP, CNT_MODE_WRAP, 0, '0, 0, all_ones);

    // Limit 0 in both modes
    repeat (3) drive(1, CNT_DIR_UP, CNT_MODE_WRAP, 0, '0, 0, 0);
    repeat (2) drive(1, CNT_DIR_DOWN, CNT_MODE_SAT, 0, '0, 0, 0);

    // Randomized phase
    r_lim = 12; r_ps = 1;
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 15))
        0: r_lim = '0;
        1: r_lim = W'($urandom_range(1, 20));
        2: r_lim = all_ones;
        3: r_lim = {1'($urandom), 32'($urandom)};
        default: ;
      endcase
      if ($urandom_range(0, 19) == 0) r_ps = PW'($urandom_range(0, 4));
      r_lv = ($urandom_range(0, 3) == 0) ? {1'($urandom), 32'($urandom)}
                                         : W'($urandom_range(0, 25));
      drive(($urandom_range(0, 4) != 0), 1'($urandom), 1'($urandom),
            ($urandom_range(0, 15) == 0), r_lv, r_ps, r_lim);
    end

    @(posedge clk);
    #2;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got=%0d expected=0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
